// File: rtl/booth_multiplier_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : booth_multiplier_seq_if
// Description : Request/response bundle of the sequential Booth multiplier:
//               operands, mode and start towards the unit; busy, done,
//               product and sign_out back from it.
// Revision    : 1.0 - initial release
// ============================================================================
interface booth_multiplier_seq_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       multipliad;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;
  logic                   sign_out;

  // Requester side (datapath issuing the multiply)
  modport master (
    output start, signed_mode, multipliad, multiplier,
    input  busy, done, product, sign_out
  );

  // Multiplier side
  modport slave (
    input  start, signed_mode, multipliad, multiplier,
    output busy, done, product, sign_out
  );
endinterface
`default_nettype wire

// File: rtl/booth_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth_multiplier_seq
// Description : Iterative radix-2 Booth multiplier, one Booth step per clock,
//               signed/unsigned operands, start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_multiplier_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  booth_multiplier_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  // Operands are carried one bit wider than WIDTH so that full-range unsigned
  // values stay positive and the Booth recoding is exact in both modes.
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH:0]       q_q, q_d;
  logic [WIDTH:0]       m_q, m_d;
  logic                 qm1_q, qm1_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sign_q, sign_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [WIDTH:0]       step_sum;
  logic [WIDTH:0]       step_a;
  logic [WIDTH:0]       step_q;

  // One Booth step: add/subtract M by the {Q0,Q-1} pair, then arithmetic
  // shift of {A,Q,Q-1} right by one.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b10:   step_sum = a_q - m_q;
      2'b01:   step_sum = a_q + m_q;
      default: step_sum = a_q;
    endcase
    step_a = {step_sum[WIDTH], step_sum[WIDTH:1]};
    step_q = {step_sum[0], q_q[WIDTH:1]};
  end

  // Next-state and datapath control for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    sign_d  = sign_q;
    prod_d  = prod_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_CALC;
          a_d     = '0;
          qm1_d   = 1'b0;
          mode_d  = bus.signed_mode;
          m_d     = {bus.signed_mode & bus.multipliad[WIDTH-1], bus.multipliad};
          q_d     = {bus.signed_mode & bus.multiplier[WIDTH-1], bus.multiplier};
          cnt_d   = CNT_W'(WIDTH + 1);
        end
      end
      ST_CALC: begin
        a_d   = step_a;
        q_d   = step_q;
        qm1_d = q_q[0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // The 2*WIDTH+2 bit {A,Q} always fits in 2*WIDTH bits, so the
          // two top bits of A are simply dropped.
          state_d = ST_DONE;
          done_d  = 1'b1;
          prod_d  = {step_a[WIDTH-2:0], step_q};
          sign_d  = mode_q & step_a[WIDTH-2];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sign_q  <= sign_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.product  = prod_q;
  assign bus.sign_out = sign_q;

endmodule
`default_nettype wire
